do_chu_ky_xung: RTL and testbench
=================================

DO_CHU_KY_XUNG -- requirements
Module: do_chu_ky_xung

Interface
REQ-001 Parameter CNT_W, default 24, width of the period counter and of the Period/HighTime outputs.
REQ-002 Parameter TIMEOUT, default 12_500_000, is the number of Clk50MHz cycles without a rising edge that flags loss of input (0.25 s, a 4 Hz floor); constraint 2 <= TIMEOUT < 2^CNT_W.
REQ-003 Clk50MHz  input  1  sole clock, 50 MHz; every flop updates on its rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 SigIn  input  1  slow asynchronous signal to measure (nominally 5 Hz).
REQ-006 Period  output  CNT_W  last measured period, in Clk50MHz cycles, rising edge to rising edge.
REQ-007 PeriodValid  output  1  one-cycle strobe marking a new Period value.
REQ-008 Timeout  output  1  level; no rising edge seen for TIMEOUT cycles.
REQ-009 HighTime  output  CNT_W  cycles SigIn was high within the last measured period (see Configuration).

Function
REQ-010 SigIn shall pass through a 2-flop synchronizer, followed by one history flop.
REQ-011 A rising edge is detected in a cycle where the synchronized value is 1 and the history flop is 0.
REQ-012 States: IDLE (unarmed, counter held at 0) and MEASURE.
REQ-013 IDLE + rising edge -> MEASURE, counter <= 1, no PeriodValid.
REQ-014 MEASURE, no edge, counter < TIMEOUT -> counter increments by 1.
REQ-015 MEASURE + rising edge -> Period <= counter, PeriodValid = 1 for exactly one cycle, Timeout <= 0, counter <= 1.
REQ-016 Result: for an input period of P cycles, Period = P exactly; the valid range is 2..TIMEOUT.
REQ-017 MEASURE, no edge, counter == TIMEOUT -> Timeout <= 1, state <= IDLE, counter <= 0; Period and HighTime hold their values.
REQ-018 A rising edge in the same cycle as counter == TIMEOUT shall win: REQ-015 applies, Period = TIMEOUT, Timeout is not set.
REQ-019 Latency: counting the Clk50MHz edge that first samples SigIn = 1 as edge 1, PeriodValid, Period and HighTime shall update at edge 3.
REQ-020 Period, HighTime and Timeout shall hold between updates.
REQ-021 Timeout clears only on PeriodValid or Rst; after a timeout, two rising edges are needed before the next PeriodValid.
REQ-022 The counter shall never wrap: it is bounded by TIMEOUT < 2^CNT_W.

Reset
REQ-023 While Rst = 1 at a clock edge: synchronizer and history flops <= 0, state <= IDLE, counter <= 0, and Period, PeriodValid, Timeout, HighTime <= 0.
REQ-024 Reset mid-measurement shall discard the partial count; the first rising edge after reset only arms the block.
REQ-025 If SigIn is high when Rst deasserts, the resulting detected edge (2 cycles later) shall be treated as an arming edge only.

Configuration
REQ-026 Macro DUTY_MEASURE_EN defined: a high-counter is set to 1 on each rising edge and increments every MEASURE cycle the synchronized SigIn is 1.
REQ-027 With DUTY_MEASURE_EN, the high-counter value is latched on the synchronized falling edge, and HighTime <= that latched value together with Period at PeriodValid.
REQ-028 Macro DUTY_MEASURE_EN undefined: no high-counter logic is built, HighTime is tied to 0, and the port remains.

Verification
REQ-029 Reset, then SigIn square wave of 100 cycles (50 high) -> no strobe on the first rise; each later rise gives a 1-cycle PeriodValid with Period = 100, HighTime = 50 (macro on) or 0 (macro off).
REQ-030 TIMEOUT = 1000, three rises at 100-cycle spacing, then SigIn low -> Timeout = 1 exactly 1000 cycles after the counter restarts, Period stays 100; next rise no strobe; following rise 100 later -> PeriodValid, Period = 100, Timeout = 0.
REQ-031 Period switches from 100 to 37 cycles -> the first strobe after the switch reports 37; edge-to-strobe latency is 3 edges as in REQ-019.
REQ-032 Rst pulsed for 1 cycle, 40 cycles into a period -> all outputs 0 next cycle; next rise no strobe; the rise after that reports the correct Period.
REQ-033 TIMEOUT = 1000, rise exactly 1000 cycles after the previous rise -> PeriodValid, Period = 1000, Timeout stays 0; at 1001 cycles -> Timeout = 1, no strobe.
REQ-034 Default parameters, 5 Hz SigIn at 50% duty -> Period = 10_000_000, HighTime = 5_000_000 (macro on), Timeout never set.

Source files
------------

// File: rtl/do_chu_ky_xung.sv
`default_nettype none
// ============================================================================
//  Module   : do_chu_ky_xung
//  Function : Measures the period (rising edge to rising edge) of a slow
//             asynchronous input in Clk50MHz cycles, flags loss of input
//             after TIMEOUT cycles without a rising edge, and optionally
//             measures the high time of the last period.
//  Options  : define DUTY_MEASURE_EN to build the high-time measurement;
//             otherwise HighTime is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module do_chu_ky_xung #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 12_500_000
) (
    input  logic             Clk50MHz,
    input  logic             Rst,
    input  logic             SigIn,
    output logic [CNT_W-1:0] Period,
    output logic             PeriodValid,
    output logic             Timeout,
    output logic [CNT_W-1:0] HighTime
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sync1;
    logic             sync2;
    logic             hist;
    logic             rise;
    logic             fall;
    logic             strobe;
    logic             expire;

    // Two-flop synchronizer for the asynchronous input plus one history flop
    always_ff @(posedge Clk50MHz) begin
        if (Rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= SigIn;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;
    assign fall = ~sync2 & hist;

    // State and period counter registers
    always_ff @(posedge Clk50MHz) begin
        if (Rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; a rise in the TIMEOUT cycle takes priority over expiry
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        strobe     = 1'b0;
        expire     = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (rise) begin
                    state_next = MEASURE;
                    cnt_next   = ONE_C;
                end
            end
            MEASURE: begin
                if (rise) begin
                    strobe   = 1'b1;
                    cnt_next = ONE_C;
                end else if (cnt >= TIMEOUT_C) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + ONE_C;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Result registers: Period and Timeout hold between updates
    always_ff @(posedge Clk50MHz) begin
        if (Rst) begin
            Period      <= '0;
            PeriodValid <= 1'b0;
            Timeout     <= 1'b0;
        end else begin
            PeriodValid <= strobe;
            if (strobe) begin
                Period  <= cnt;
                Timeout <= 1'b0;
            end else if (expire) begin
                Timeout <= 1'b1;
            end
        end
    end

`ifdef DUTY_MEASURE_EN
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] high_latch;
    logic [CNT_W-1:0] high_time;

    // High-time counter: restarts on each rise, captured on the falling
    // edge, and published alongside Period on the strobe. It cannot wrap
    // because MEASURE never lasts longer than TIMEOUT cycles.
    always_ff @(posedge Clk50MHz) begin
        if (Rst) begin
            high_cnt   <= '0;
            high_latch <= '0;
            high_time  <= '0;
        end else begin
            if (rise) begin
                high_cnt <= ONE_C;
            end else if (state == MEASURE && sync2) begin
                high_cnt <= high_cnt + ONE_C;
            end
            if (fall) begin
                high_latch <= high_cnt;
            end
            if (strobe) begin
                high_time <= high_latch;
            end
        end
    end

    assign HighTime = high_time;
`else
    assign HighTime = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_do_chu_ky_xung.sv
`default_nettype none
// ============================================================================
//  Module   : tb_do_chu_ky_xung
//  Function : Self-checking bench for do_chu_ky_xung (TIMEOUT scaled to 1000).
//             A reference model predicts each strobe (cycle, Period,
//             HighTime) when a rising edge is driven; a monitor compares on
//             every strobe. HighTime expectations follow DUTY_MEASURE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_do_chu_ky_xung;

    localparam int CNT_W   = 24;
    localparam int TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic [CNT_W-1:0] high_time;

    do_chu_ky_xung #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk50MHz    (clk),
        .Rst         (rst),
        .SigIn       (sig),
        .Period      (period),
        .PeriodValid (period_valid),
        .Timeout     (timeout),
        .HighTime    (high_time)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int per;
        int hi;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit armed     = 1'b0;
    int last_rise = 0;
    int hi_start  = 0;
    int last_high = 0;

    task automatic chk(input string tag, input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int exp_high(input int h);
`ifdef DUTY_MEASURE_EN
        return h;
`else
        return 0 * h;
`endif
    endfunction

    // Drive a rising edge; if the model is armed and within TIMEOUT, a strobe
    // is due three clock edges later reporting the elapsed cycles.
    task automatic do_rise();
        exp_t e;
        if (armed && (cyc - last_rise) <= TIMEOUT) begin
            e.cyc = cyc + 3;
            e.per = cyc - last_rise;
            e.hi  = exp_high(last_high);
            exp_q.push_back(e);
        end
        armed     = 1'b1;
        last_rise = cyc;
        hi_start  = cyc;
        sig       = 1'b1;
    endtask

    task automatic do_fall();
        last_high = cyc - hi_start;
        sig       = 1'b0;
    endtask

    task automatic pulse(input int hi, input int lo);
        do_rise();
        tick(hi);
        do_fall();
        tick(lo);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_valid"}, period_valid, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_high"}, high_time, 0);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expectation
    always @(negedge clk) begin
        if (period_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", period_valid, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("period", period, e.per);
                chk("high_time", high_time, e.hi);
                chk("timeout_at_strobe", timeout, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(negedge clk);
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(5);

        // Square wave, 100-cycle period, 50 high: first rise only arms
        for (int i = 0; i < 4; i++) pulse(50, 50);

        // Loss of input: Timeout exactly 1000 cycles after counter restart
        tick(last_rise + 1002 - cyc);
        chk("timeout_not_early", timeout, 0);
        tick(1);
        chk("timeout_set", timeout, 1);
        chk("period_hold", period, 100);

        // Arming rise after timeout: no strobe, Timeout stays set
        do_rise();
        tick(5);
        chk("timeout_hold_after_arm", timeout, 1);
        tick(45);
        do_fall();
        tick(50);
        pulse(50, 50);

        // Period switch 100 -> 37
        for (int i = 0; i < 3; i++) pulse(20, 17);

        // Reset pulse 40 cycles into a period
        do_rise();
        tick(20);
        do_fall();
        tick(20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        armed = 1'b0;
        check_all_zero("mid_reset");
        tick(60);
        pulse(50, 50);
        pulse(50, 50);

        // Boundary: rise exactly TIMEOUT after the previous one
        pulse(50, 950);
        pulse(50, 951);
        do_rise();
        tick(3);
        chk("timeout_at_1001", timeout, 1);
        tick(47);
        do_fall();
        tick(50);
        pulse(50, 50);

        // SigIn already high when reset deasserts: only arms
        rst = 1'b1;
        sig = 1'b1;
        tick(2);
        rst = 1'b0;
        armed = 1'b0;
        do_rise();
        tick(30);
        do_fall();
        tick(70);
        pulse(30, 70);
        tick(10);

        chk("missing_strobes", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
